// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-front-end definitions: zigzag scan tables, token
// struct, scan FSM states and default coefficient/amplitude widths.
// Used by the Cb zigzag/RLE block and reusable by the Y/Cr paths.
package jpeg_pkg;

    localparam int COEF_W_DFLT = 11;
    localparam int AMP_W_DFLT  = 12;

    // Zigzag index -> (row, col) of the 8x8 block.
    localparam logic [2:0] ZIGZAG_ROW [64] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
        3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
    };
    localparam logic [2:0] ZIGZAG_COL [64] = '{
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
        3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
        3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
        3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DC,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic                  is_dc;
        logic                  eob;
        logic [3:0]            run;
        logic [3:0]            size;
        logic [AMP_W_DFLT-1:0] amp;
    } token_t;

    function automatic token_t make_tok(input logic is_dc, input logic eob,
                                        input logic [3:0] run, input logic [3:0] size,
                                        input logic [AMP_W_DFLT-1:0] amp);
        token_t t;
        t.is_dc = is_dc;
        t.eob   = eob;
        t.run   = run;
        t.size  = size;
        t.amp   = amp;
        return t;
    endfunction

endpackage

// File: rtl/jpeg_mag_category.sv
// JPEG magnitude category: signed value -> {size, amplitude bits}.
// Ports: val_i signed input; size_o = bit length of |val_i|; amp_o = val_i
// for positive, (val_i-1) masked to size_o bits for negative. Purely combinational.
module jpeg_mag_category #(
    parameter int AMP_W = 12
) (
    input  logic signed [AMP_W-1:0] val_i,
    output logic        [3:0]       size_o,
    output logic        [AMP_W-1:0] amp_o
);

    logic [AMP_W-1:0] uval;
    logic [AMP_W-1:0] abs_v;
    logic [AMP_W-1:0] mask;

    always_comb begin
        uval   = val_i;
        abs_v  = val_i[AMP_W-1] ? (~uval + 1'b1) : uval;
        size_o = '0;
        for (int i = 0; i < AMP_W; i++) begin
            if (abs_v[i]) size_o = 4'(i + 1);
        end
        mask = '0;
        for (int i = 0; i < AMP_W; i++) begin
            mask[i] = (i < int'(size_o));
        end
        // Negative values use one's-complement style amplitude bits.
        amp_o = val_i[AMP_W-1] ? ((uval - 1'b1) & mask) : uval;
    end

endmodule

// File: rtl/cb_zigzag_rle.sv
// Cb zigzag scanner and run-length tokenizer: captures an 8x8 block, emits
// DC-difference then AC (run,size,amp) tokens with ZRL/EOB over valid/ready.
// Ports: clk/rst (sync, active-high); enable/Q/in_ready block input;
// out_valid/out_ready token stream with out_is_dc/run/size/amp/eob;
// block_done pulse. Optional CB_RLE_STATS_EN adds nz_count output.
module cb_zigzag_rle
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_W_DFLT,
    parameter int AMP_W  = AMP_W_DFLT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic signed [0:7][0:7][COEF_W-1:0] Q,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_is_dc,
    output logic [3:0]                      out_run,
    output logic [3:0]                      out_size,
    output logic [AMP_W-1:0]                out_amp,
    output logic                            out_eob,
    output logic                            block_done
`ifdef CB_RLE_STATS_EN
    ,
    output logic [6:0]                      nz_count
`endif
);

    state_t                    state_q, state_d;
    logic signed [COEF_W-1:0]  coef_q [64];     // stored in zigzag order
    logic [5:0]                k_q, k_d;
    logic [5:0]                zrun_q, zrun_d;
    logic signed [AMP_W-1:0]   pred_q, pred_d;
    token_t                    tok_q, tok_d;
    logic                      last_q, last_d;  // token in tok_q ends the block

    logic signed [COEF_W-1:0]  cur;
    logic signed [AMP_W-1:0]   cur_ext, dc_ext, diff, cat_val;
    logic [3:0]                cat_size;
    logic [AMP_W-1:0]          cat_amp;
    logic                      accept;

    assign cur     = coef_q[k_q];
    assign cur_ext = {{(AMP_W-COEF_W){cur[COEF_W-1]}}, cur};
    assign dc_ext  = {{(AMP_W-COEF_W){coef_q[0][COEF_W-1]}}, coef_q[0]};
    assign diff    = dc_ext - pred_q;
    assign cat_val = (state_q == ST_DC) ? diff : cur_ext;
    assign accept  = enable && in_ready;

    // One categorizer serves both the DC difference and the AC coefficient.
    jpeg_mag_category #(.AMP_W(AMP_W)) u_cat (
        .val_i  (cat_val),
        .size_o (cat_size),
        .amp_o  (cat_amp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            zrun_q  <= '0;
            pred_q  <= '0;
            tok_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            zrun_q  <= zrun_d;
            pred_q  <= pred_d;
            tok_q   <= tok_d;
            last_q  <= last_d;
        end
    end

    // Block storage needs no reset; it is always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 64; i++) begin
                coef_q[i] <= Q[ZIGZAG_ROW[i]][ZIGZAG_COL[i]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        zrun_d  = zrun_q;
        pred_d  = pred_q;
        tok_d   = tok_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = enable ? ST_DC : ST_IDLE;
            end
            ST_DC: begin
                tok_d   = make_tok(1'b1, 1'b0, 4'd0, cat_size, cat_amp);
                last_d  = 1'b0;
                state_d = ST_EMIT;
            end
            ST_SCAN: begin
                if (cur == '0) begin
                    if (k_q == 6'd63) begin
                        // Trailing zeros: any pending ZRLs collapse into EOB.
                        tok_d   = make_tok(1'b0, 1'b1, 4'd0, 4'd0, '0);
                        last_d  = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        zrun_d = zrun_q + 6'd1;
                        k_d    = k_q + 6'd1;
                    end
                end else if (zrun_q >= 6'd16) begin
                    // ZRL, then re-examine the same coefficient.
                    tok_d   = make_tok(1'b0, 1'b0, 4'd15, 4'd0, '0);
                    zrun_d  = zrun_q - 6'd16;
                    last_d  = 1'b0;
                    state_d = ST_EMIT;
                end else begin
                    tok_d   = make_tok(1'b0, 1'b0, zrun_q[3:0], cat_size, cat_amp);
                    zrun_d  = '0;
                    k_d     = k_q + 6'd1;
                    last_d  = (k_q == 6'd63);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (tok_q.is_dc) begin
                        pred_d  = dc_ext;
                        k_d     = 6'd1;
                        zrun_d  = '0;
                        state_d = ST_SCAN;
                    end else begin
                        state_d = last_q ? ST_DONE : ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
        out_valid  = (state_q == ST_EMIT);
        block_done = (state_q == ST_DONE);
        out_is_dc  = tok_q.is_dc;
        out_eob    = tok_q.eob;
        out_run    = tok_q.run;
        out_size   = tok_q.size;
        out_amp    = tok_q.amp;
    end

`ifdef CB_RLE_STATS_EN
    logic [6:0] nz_q, nz_d, stats_q, stats_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            nz_q    <= '0;
            stats_q <= '0;
        end else begin
            nz_q    <= nz_d;
            stats_q <= stats_d;
        end
    end

    // Count nonzeros as they are tokenized; publish when the block completes.
    always_comb begin
        nz_d    = nz_q;
        stats_d = stats_q;
        if (state_q == ST_DC) begin
            nz_d = (coef_q[0] != '0) ? 7'd1 : 7'd0;
        end else if (state_q == ST_SCAN && cur != '0 && zrun_q < 6'd16) begin
            nz_d = nz_q + 7'd1;
        end
        if (state_q == ST_EMIT && out_ready && last_q && !tok_q.is_dc) begin
            stats_d = nz_q;
        end
    end

    assign nz_count = stats_q;
`endif

endmodule

// File: tb/tb_cb_zigzag_rle.sv
module tb_cb_zigzag_rle;

    localparam int CW = 11;
    localparam int AW = 12;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      enable;
    logic [0:7][0:7][CW-1:0]   q_s;
    logic                      in_ready, out_valid, out_ready;
    logic                      out_is_dc, out_eob, block_done;
    logic [3:0]                out_run, out_size;
    logic [AW-1:0]             out_amp;
`ifdef CB_RLE_STATS_EN
    logic [6:0]                nz_count;
`endif

    always #5 clk = ~clk;

    cb_zigzag_rle dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .Q          (q_s),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_dc  (out_is_dc),
        .out_run    (out_run),
        .out_size   (out_size),
        .out_amp    (out_amp),
        .out_eob    (out_eob),
        .block_done (block_done)
`ifdef CB_RLE_STATS_EN
        ,
        .nz_count   (nz_count)
`endif
    );

    typedef struct {
        bit dc;
        bit eob;
        int run;
        int size;
        int amp;
        bit last;
    } etok_t;

    etok_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    pred_m = 0;
    int    zz_r [64];
    int    zz_c [64];
    int    blk  [8][8];
    int    rmode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Zigzag order generated by walking anti-diagonals in alternating direction.
    function automatic void build_zigzag();
        int n, lo, hi;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_r[n] = r; zz_c[n] = s - r; n++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_r[n] = r; zz_c[n] = s - r; n++;
                end
            end
        end
    endfunction

    function automatic etok_t mk(bit dc, bit eob, int run, int v, bit last);
        etok_t e;
        int a, sz;
        a  = (v < 0) ? -v : v;
        sz = 0;
        while (a > 0) begin sz++; a = a >> 1; end
        e.dc = dc; e.eob = eob; e.run = run; e.size = sz; e.last = last;
        e.amp = (v >= 0) ? v : ((v - 1) & ((1 << sz) - 1));
        return e;
    endfunction

    function automatic void model_block();
        int run, v;
        sb.push_back(mk(1'b1, 1'b0, 0, blk[0][0] - pred_m, 1'b0));
        pred_m = blk[0][0];
        run = 0;
        for (int i = 1; i < 64; i++) begin
            v = blk[zz_r[i]][zz_c[i]];
            if (v == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    sb.push_back(mk(1'b0, 1'b0, 15, 0, 1'b0));
                    run -= 16;
                end
                sb.push_back(mk(1'b0, 1'b0, run, v, i == 63));
                run = 0;
            end
        end
        if (blk[7][7] == 0) sb.push_back(mk(1'b0, 1'b1, 0, 0, 1'b1));
    endfunction

    function automatic int rnd_coef();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 2047)) - 1024;
        return int'($urandom_range(0, 14)) - 7;
    endfunction

    function automatic void clear_blk();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) blk[r][c] = 0;
    endfunction

    task automatic send_block();
        int t;
        t = 0;
        while (!in_ready && t < 3000) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            chk("in_ready_wait", {31'd0, in_ready}, 1);
            return;
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) q_s[r][c] = CW'(blk[r][c]);
        model_block();
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        chk("busy_in_ready", {31'd0, in_ready}, 0);
        chk("dc_lat1_valid", {31'd0, out_valid}, 0);
        @(posedge clk); #1;
        chk("dc_lat2_valid", {31'd0, out_valid}, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 5000) begin @(posedge clk); #1; t++; end
        chk("drain_in_time", {31'd0, t < 5000}, 1);
        chk("sb_empty", sb.size(), 0);
        chk("in_ready_back", {31'd0, in_ready}, 1);
    endtask

    // Downstream ready generator.
    initial begin
        int hold;
        hold = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid) begin
                        if (hold < 5) begin out_ready = 1'b0; hold++; end
                        else begin out_ready = 1'b1; hold = 0; end
                    end else begin
                        out_ready = 1'b0;
                    end
                end
            endcase
        end
    end

    // Monitor: pops expected tokens on each handshake.
    initial begin
        etok_t e;
        bit    stall, done_pend;
        logic  [AW+10:0] saved;
        stall = 0; done_pend = 0; saved = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0; done_pend = 0;
            end else begin
                if (done_pend || block_done)
                    chk("block_done", {31'd0, block_done}, {31'd0, done_pend});
                done_pend = 0;
                if (stall) begin
                    chk("stall_valid", {31'd0, out_valid}, 1);
                    chk("stall_fields", 32'({out_is_dc, out_eob, out_run, out_size, out_amp}),
                        32'(saved));
                end
                if (out_valid && out_ready) begin
                    stall = 0;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_token: got run %0d size %0d expected none",
                                 out_run, out_size);
                    end else begin
                        e = sb.pop_front();
                        chk("tok_is_dc", {31'd0, out_is_dc}, {31'd0, e.dc});
                        chk("tok_eob",   {31'd0, out_eob},   {31'd0, e.eob});
                        chk("tok_run",   32'(out_run),  e.run);
                        chk("tok_size",  32'(out_size), e.size);
                        chk("tok_amp",   32'(out_amp),  e.amp);
                        if (e.last) done_pend = 1;
                    end
                end else if (out_valid) begin
                    stall = 1;
                    saved = {out_is_dc, out_eob, out_run, out_size, out_amp};
                end else begin
                    stall = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        build_zigzag();
        rst = 1'b1; enable = 1'b0; q_s = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",   {31'd0, in_ready},   1);
        chk("rst_out_valid",  {31'd0, out_valid},  0);
        chk("rst_block_done", {31'd0, block_done}, 0);
        chk("rst_out_fields", 32'({out_is_dc, out_eob, out_run, out_size, out_amp}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-zero block.
        clear_blk(); send_block(); drain();
        // DC 5 then DC -3 (difference -8).
        clear_blk(); blk[0][0] = 5;  send_block(); drain();
        clear_blk(); blk[0][0] = -3; send_block(); drain();
        // Single AC at zigzag index 1 (DC diff back to zero needs pred 0 block).
        clear_blk(); send_block(); drain();
        clear_blk(); blk[0][1] = 1; send_block(); drain();
        // Only last coefficient nonzero: three ZRLs then run 14.
        clear_blk(); blk[7][7] = -1; send_block(); drain();

        // Backpressure with ignored enables while busy.
        rmode = 2;
        clear_blk(); blk[0][1] = 1; send_block();
        for (int i = 0; i < 30; i++) begin
            if (!in_ready) begin
                q_s[0][0] = CW'($urandom_range(1, 200));
                enable = 1'b1;
            end
            @(posedge clk); #1;
            enable = 1'b0;
        end
        drain();

        // Random blocks with random downstream stalls.
        rmode = 1;
        for (int b = 0; b < 25; b++) begin
            clear_blk();
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (int'($urandom_range(0, 99)) < 5 + b * 3) blk[r][c] = rnd_coef();
            if (b % 4 == 1) blk[7][7] = rnd_coef() | 1;
            blk[0][0] = rnd_coef();
            send_block();
        end
        drain();

        // Reset in the middle of a dense block.
        rmode = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                blk[r][c] = rnd_coef();
                if (blk[r][c] == 0) blk[r][c] = 1;
            end
        send_block();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        pred_m = 0;
        @(posedge clk); #1;
        chk("midrst_in_ready",  {31'd0, in_ready},  1);
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        rst = 1'b0;
        clear_blk(); blk[0][0] = 4; send_block(); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_zigzag_rle.md
Name: cb_zigzag_rle

Overview:
- Downstream consumer of the Cb quantizer.
- Captures one 8x8 block of 11-bit signed quantized coefficients on a one-cycle enable pulse.
- Scans the block in JPEG zigzag order and emits Huffman-ready tokens: one DC-difference token, then AC (run, size, amplitude) tokens with ZRL and EOB.
- Tokens leave over a valid/ready stream to the Cb entropy coder.

Parameters:
- COEF_W, 11, width of input coefficients (signed).
- AMP_W, 12, width of the amplitude output; holds the DC difference range.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  one-cycle pulse; Q valid this cycle. Accepted only when in_ready=1.
- Q  in  [0:7][0:7] x COEF_W signed  quantized block, row-major [row][col].
- in_ready  out  1  high when idle and able to accept a block.
- out_valid  out  1  token present on the out_* signals.
- out_ready  in  1  downstream accepts the token when out_valid and out_ready are both high.
- out_is_dc  out  1  token is the DC difference.
- out_run  out  4  preceding zero run; 0 for DC.
- out_size  out  4  magnitude category, 0..11.
- out_amp  out  AMP_W  JPEG amplitude bits, low out_size bits significant, upper bits zero.
- out_eob  out  1  token is EOB (run 0, size 0).
- block_done  out  1  one-cycle pulse on acceptance of the block's last token.

Behaviour:
- Reset values:
  - in_ready=1; all other outputs 0.
  - DC predictor=0; FSM=IDLE.
  - A reset mid-block discards the block and the predictor.
- FSM states: IDLE, DC, SCAN, EMIT, DONE.
- IDLE:
  - When enable=1, register all 64 coefficients and go to DC; in_ready=0 from the next cycle.
  - enable when in_ready=0 is ignored. The quantizer must not pulse while busy.
- DC:
  - diff = Q[0][0] - pred, computed at AMP_W bits.
  - Present the token next cycle: out_is_dc=1, run=0.
  - On handshake: pred <= Q[0][0], k=1, zero_run=0, go to SCAN.
- Size and amplitude:
  - size = bit length of |v|; size=0 for v=0.
  - amp = v for v>0; (v-1) masked to size bits for v<0.
- SCAN: examine zigzag index k, one coefficient per cycle, using the standard JPEG zigzag table.
  - Zero coefficient: zero_run++, k++, no token.
  - Nonzero, zero_run>=16: emit ZRL (run=15, size=0, amp=0) via EMIT, zero_run-=16, stay at k.
  - Nonzero, zero_run<16: emit (zero_run, size, amp) via EMIT, zero_run=0, k++.
  - After k=63 is processed: if index 63 was zero, emit EOB; pending ZRLs are dropped, never emitted before EOB. If index 63 was nonzero, no EOB.
- EMIT:
  - Hold out_* and out_valid stable until out_ready. Contents must not change under backpressure.
  - On handshake, return to SCAN, or go to DONE after the last token.
- DONE: block_done=1 for one cycle, in_ready=1, go to IDLE.
- out_valid deasserts the cycle after handshake unless the next token is ready. One token per handshake; no token is ever dropped.
- Minimum latency: enable to first DC out_valid = 2 cycles. Worst-case block time ~64 + tokens cycles with out_ready=1.

Optional Feature:
- Macro: CB_RLE_STATS_EN.
- Defined:
  - Adds output nz_count [6:0]: count of nonzero coefficients, DC included, in the last completed block.
  - Updated in the block_done cycle; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package jpeg_pkg holds:
  - ZIGZAG_ROW/ZIGZAG_COL constant arrays (64 entries).
  - The token struct typedef {is_dc, eob, run, size, amp}.
  - FSM state enum.
  - COEF_W and AMP_W defaults.
- One sub-module: jpeg_mag_category, combinational value to {size, amp}. Shared by the DC and AC paths, reusable by the Y/Cr blocks.

Test Plan:
- All-zero block, pred 0 -> DC (size 0, amp 0), then EOB, then block_done; in_ready returns to 1.
- Q[0][0]=5 after reset, others 0 -> DC size 3, amp 5, EOB. Next block Q[0][0]=-3 -> diff -8: size 4, amp 4'b0111, EOB.
- Q[0][1]=1 only -> DC size 0, AC (run 0, size 1, amp 1), EOB.
- Q[7][7]=-1 only (zigzag index 63) -> DC, three ZRL (15/0), then (run 14, size 1, amp 0); no EOB.
- Backpressure: Q[0][1]=1, hold out_ready=0 for 5 cycles at each token -> out_* stable; identical token sequence; extra enable pulses while busy ignored.
- Reset asserted during SCAN -> in_ready=1, out_valid=0 next cycle. Next block Q[0][0]=4 -> DC diff 4 (pred cleared).
